mux_sel_pipe: RTL and testbench
===============================

// Module: mux_sel_pipe
// PURPOSE
//   Parametrised N:1 datapath select with a registered, back-pressured output.
//   Successor to the 16-bit 2:1 operand mux. Sits between register-file/ALU
//   sources and a pipeline stage that can stall.
//   Selects one of NUM_IN words per accepted transfer. Output uses valid/ready
//   through a 2-entry skid buffer, so full throughput holds under stalls.
// PARAMETERS
//   WIDTH    16                      data bits per input word
//   NUM_IN   4                       number of inputs, >= 2
//   SEL_W    $clog2(NUM_IN)          select width, derived (localparam)
// PORTS
//   clk        in   1               single clock, rising edge
//   reset      in   1               asynchronous, active-high reset
//   in_bus     in   NUM_IN*WIDTH    packed inputs; word k = in_bus[k*WIDTH +: WIDTH]
//   sel        in   SEL_W           index of the word to forward
//   in_valid   in   1               upstream offers {in_bus, sel} this cycle
//   in_ready   out  1               block can accept this cycle
//   out_data   out  WIDTH           selected word
//   out_sel    out  SEL_W           sel value that produced out_data
//   out_err    out  1               sel was >= NUM_IN; out_data forced to 0
//   out_valid  out  1               out_* valid
//   out_ready  in   1               downstream accepts this cycle
// BEHAVIOUR
//   - Accept when in_valid & in_ready. Transfer out when out_valid & out_ready.
//   - Storage is a main register (M) plus a skid register (S), each with its own valid bit.
//   - in_ready = ~S_valid, a registered signal. It never depends combinationally on out_ready.
//   - out_* always come from M. No combinational path from input to output.
//     Latency is 1 cycle: a word accepted at edge n appears on out_* after edge n.
//   - Mux function: sel < NUM_IN gives in_bus word[sel] and err=0.
//     sel >= NUM_IN gives 0 and err=1. Only possible when NUM_IN is not a power of 2.
//   - Per-edge updates, evaluated in priority order:
//     a) M empty, or M transferring this cycle, with S_valid: S moves into M, S empties.
//        In this case in_ready was 0, so nothing is accepted.
//     b) M empty, or M transferring, with S empty: an accepted word loads into M.
//        With no accept, M_valid clears.
//     c) M full and stalled: an accepted word loads into S and S_valid is set.
//   - M holds its data, sel and err stable while out_valid=1 and out_ready=0.
//   - Simultaneous accept and transfer with S empty sustains 1 word/cycle.
//   - Order is strictly FIFO. No word is dropped or duplicated.
//   - Reset (async assert, sync deassert is upstream's job) drives:
//     out_valid=0, S_valid=0, out_data=0, out_sel=0, out_err=0.
//     in_ready reads 1 from the first cycle after reset.
//     Reset mid-transfer discards both entries.
//   - in_bus and sel are ignored whenever in_valid=0 or in_ready=0.
// TESTING
//   1. Reset check: assert reset while M and S are full.
//      out_valid=0 and out_data=0 immediately. in_ready=1 after release.
//   2. Streaming: NUM_IN=4, out_ready=1, in_bus={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}.
//      sel=0,1,2,3 on consecutive cycles gives AAAA,BBBB,CCCC,DDDD on consecutive cycles
//      with out_sel echoed and no bubbles.
//   3. Stall: out_ready=0 with 3 words offered. Words 1 and 2 are accepted and in_ready drops.
//      Word 3 is held off. With out_ready=1 the output is words 1,2,3 in order,
//      with no loss and no repeat.
//   4. Random back-pressure: 1000 transfers with random in_valid and out_ready.
//      The scoreboard matches every word and out_sel. out_* never change while stalled.
//   5. NUM_IN=3 build, sel=3: out_data=0 and out_err=1.
//      sel=2 returns word 2 with out_err=0.
//   6. WIDTH=32, NUM_IN=8 build: repeat scenario 2 with sel=7 selecting the top word.

Source files
------------

// File: rtl/mux_sel_pipe.sv
// N:1 word select feeding a valid/ready output through a main + skid register.
// in_ready is registered, so upstream never sees a combinational path from out_ready.
module mux_sel_pipe #(
  parameter  int WIDTH  = 16,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } ent_t;

  ent_t m_q, m_d;
  ent_t s_q, s_d;
  logic m_vld_q, m_vld_d;
  logic s_vld_q, s_vld_d;
  ent_t mux_e;
  logic accept;
  logic m_free;

  // Unmatched indices (only reachable when NUM_IN is not a power of 2) flag err.
  always_comb begin
    mux_e.data = '0;
    mux_e.sel  = sel;
    mux_e.err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        mux_e.data = in_bus[k*WIDTH +: WIDTH];
        mux_e.err  = 1'b0;
      end
    end
  end

  assign in_ready = ~s_vld_q;
  assign accept   = in_valid & ~s_vld_q;
  assign m_free   = ~m_vld_q | out_ready;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (m_free) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (accept) begin
        m_d     = mux_e;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_d     = mux_e;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  assign out_data  = m_q.data;
  assign out_sel   = m_q.sel;
  assign out_err   = m_q.err;
  assign out_valid = m_vld_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: a 4-input and a 3-input build.
// Occupancy model predicts in_ready/out_valid; queues predict the word stream.
module tb_mux_sel_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  s;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_bus = '0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [47:0] in_bus3 = '0;
  logic [1:0]  sel3 = '0;
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [15:0] out_data3;
  logic [1:0]  out_sel3;
  logic        out_err3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int n_xf = 0;
  exp_t q[$];
  exp_t q3[$];

  mux_sel_pipe #(.WIDTH(16), .NUM_IN(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_bus(in_bus), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel),
    .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_sel_pipe #(.WIDTH(16), .NUM_IN(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .in_bus(in_bus3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3),
    .out_err(out_err3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  // Reference: word k is bits [16k +: 16]; out-of-range index yields 0 with err.
  function automatic exp_t model(input logic [63:0] bus,
                                 input int unsigned idx,
                                 input int unsigned n);
    exp_t e;
    e.s = 2'(idx);
    if (idx < n) begin
      e.d = 16'((bus >> (16 * idx)) & 64'hFFFF);
      e.e = 1'b0;
    end else begin
      e.d = 16'h0;
      e.e = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic iv, input logic [1:0] s,
                       input logic [63:0] bus, input logic ordy);
    logic acc, xf;
    @(posedge clk);
    #1;
    in_valid  = iv;
    sel       = s;
    in_bus    = bus;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(cnt < 2));
    chk("out_valid", 32'(out_valid), 32'(cnt > 0));
    acc = in_valid & in_ready;
    xf  = out_valid & out_ready;
    if (acc) q.push_back(model(in_bus, sel, 4));
    if (in_valid3 & in_ready3)
      q3.push_back(model({16'h0, in_bus3}, sel3, 3));
    cnt = cnt + int'(acc) - int'(xf);
    if (xf) n_xf++;
  endtask

  logic stall_prev = 1'b0;
  exp_t held;

  always @(negedge clk) begin
    exp_t got, e;
    got = '{d: out_data, s: out_sel, e: out_err};
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (got !== held) begin
          errors++;
          $display("FAIL stall_hold got %h expected %h", got, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h expected none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out4 got %h expected %h", got, e);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = got;
    end
  end

  always @(negedge clk) begin
    exp_t got, e;
    got = '{d: out_data3, s: out_sel3, e: out_err3};
    if (!reset && out_valid3 && out_ready3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out3 got %h expected none", got);
      end else begin
        e = q3.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out3 got %h expected %h", got, e);
        end
      end
    end
  end

  initial begin
    logic [63:0] pat;
    int guard;
    pat = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming, no bubbles.
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);

    // Stall: two words land, third is held off, then release.
    cycle(1'b1, 2'd1, pat, 1'b0);
    cycle(1'b1, 2'd2, pat, 1'b0);
    cycle(1'b1, 2'd3, pat, 1'b0);
    cycle(1'b1, 2'd3, pat, 1'b0);
    cycle(1'b1, 2'd3, pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);
    chk("stall_drained", 32'(q.size()), 32'd0);

    // Out-of-range and top index on the 3-input build.
    in_bus3   = {16'h3333, 16'h2222, 16'h1111};
    in_valid3 = 1'b1;
    sel3      = 2'd3;
    cycle(1'b0, 2'd0, pat, 1'b1);
    sel3 = 2'd2;
    cycle(1'b0, 2'd0, pat, 1'b1);
    in_valid3 = 1'b0;
    cycle(1'b0, 2'd0, pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);
    chk("err_drained", 32'(q3.size()), 32'd0);

    // Random traffic with back-pressure.
    n_xf  = 0;
    guard = 0;
    while (n_xf < 1000 && guard < 6000) begin
      in_valid3 = 1'($urandom_range(0, 1));
      sel3      = 2'($urandom_range(0, 3));
      in_bus3   = {$urandom, 16'($urandom)};
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      guard++;
    end
    chk("rand_budget", 32'(n_xf >= 1000), 32'd1);
    in_valid3 = 1'b0;
    guard = 0;
    while ((cnt > 0 || q3.size() > 0) && guard < 20) begin
      cycle(1'b0, 2'd0, '0, 1'b1);
      guard++;
    end
    cycle(1'b0, 2'd0, '0, 1'b1);
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset with both entries full.
    cycle(1'b1, 2'd2, pat, 1'b0);
    cycle(1'b1, 2'd3, pat, 1'b0);
    cycle(1'b1, 2'd0, pat, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_err", 32'(out_err), 32'd0);
    q.delete();
    q3.delete();
    cnt = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    cycle(1'b1, 2'd1, pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);
    cycle(1'b0, 2'd0, pat, 1'b1);
    chk("post_rst_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
